clock_set_controller: RTL and testbench

Mode sequencer and time-setting controller for the time-of-day clock. It debounces the two front-panel keys (MODE, INC) and steps a display/edit state machine. It gates the running hour/minute counters with `run_en` and issues one-cycle load strobes that write user-edited hour/minute values into them. It also drives the 12-bit display word and per-field blink masks consumed by the segment display driver.

---
 rtl/clock_set_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_clock_set_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// clock_set_controller
//   Mode sequencer and time-setting controller for the time-of-day clock.
//   Debounces the MODE and INC keys, steps the display/edit state machine,
//   gates the running hour/minute counters, issues load strobes that write
//   edited values into them, and drives the display word and blink masks.
//
// Ports
//   clock, reset        system clock (rising edge), async active-low reset
//   sample_tick         debounce sample strobe
//   blink_tick          blink phase toggle strobe
//   key_mode_raw        MODE key, asynchronous, active-high
//   key_inc_raw         INC key, asynchronous, active-high
//   hour_in/minute_in/second_in   live counter values
//   run_en              1 lets the minute/hour counters advance
//   hour_load/minute_load/second_clear   one-cycle strobes to the counters
//   hour_value/minute_value              edited values (edit registers)
//   mode                current state code
//   data_show           {enable, hour field, minute field}
//   blank_mask          bit1 blanks hour digits, bit0 blanks minute digits

// Per-key input path: 2-flop synchronizer, 4-sample shift register on
// sample_tick, 3-of-4 majority level and a one-cycle rising-edge press.
module clock_set_key_filter (
    input  logic clock,
    input  logic reset,
    input  logic sample_tick,
    input  logic key_raw,
    output logic level,
    output logic press
);
    logic [1:0] sync;
    logic [3:0] samples;
    logic       level_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync    <= 2'b00;
            samples <= 4'b0000;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], key_raw};
            if (sample_tick)
                samples <= {samples[2:0], sync[1]};
            level_q <= level;
        end
    end

    // Majority: any three of the four samples high.
    assign level = (samples[3] & samples[2] & samples[1]) |
                   (samples[3] & samples[2] & samples[0]) |
                   (samples[3] & samples[1] & samples[0]) |
                   (samples[2] & samples[1] & samples[0]);
    assign press = level & ~level_q;
endmodule

module clock_set_controller #(
    parameter int REPEAT_DELAY = 48,
    parameter int REPEAT_RATE  = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        blink_tick,
    input  logic        key_mode_raw,
    input  logic        key_inc_raw,
    input  logic [4:0]  hour_in,
    input  logic [5:0]  minute_in,
    input  logic [5:0]  second_in,
    output logic        run_en,
    output logic        hour_load,
    output logic [4:0]  hour_value,
    output logic        minute_load,
    output logic [5:0]  minute_value,
    output logic        second_clear,
    output logic [2:0]  mode,
    output logic [11:0] data_show,
    output logic [1:0]  blank_mask
);
    localparam int NUM_KEYS = 2;
    localparam int KEY_MODE = 0;
    localparam int KEY_INC  = 1;
    localparam logic [7:0] DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE  = 8'(REPEAT_RATE);

    typedef enum logic [2:0] {
        SHOW_TIME = 3'd0,
        SHOW_SEC  = 3'd1,
        SET_HOUR  = 3'd2,
        SET_MIN   = 3'd3,
        STOPPED   = 3'd4
    } state_t;

    state_t state;

    logic [NUM_KEYS-1:0] key_raw, key_level, key_press;
    assign key_raw = {key_inc_raw, key_mode_raw};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        clock_set_key_filter u_filt (
            .clock       (clock),
            .reset       (reset),
            .sample_tick (sample_tick),
            .key_raw     (key_raw[k]),
            .level       (key_level[k]),
            .press       (key_press[k])
        );
    end

    logic [4:0] edit_hour;
    logic [5:0] edit_min;
    logic       phase, phase_next;

    logic mode_evt, inc_evt, state_valid, state_change, in_set;
    assign mode_evt     = key_press[KEY_MODE];
    assign state_valid  = (state <= STOPPED);
    assign state_change = mode_evt | ~state_valid;
    assign in_set       = (state == SET_HOUR) || (state == SET_MIN);

    // Auto-repeat: one counter serves both the initial delay and the
    // repeat interval; 'repeating' selects which target it counts toward.
    logic [7:0] hold_cnt, hold_next, hold_target;
    logic       repeating, rep_evt;
    assign hold_next   = hold_cnt + 8'd1;
    assign hold_target = repeating ? RATE : DELAY;
    assign rep_evt     = in_set & key_level[KEY_INC] & sample_tick &
                         (hold_next == hold_target);

    // MODE wins over a coincident INC event.
    assign inc_evt = (key_press[KEY_INC] | rep_evt) & ~mode_evt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= 8'd0;
            repeating <= 1'b0;
        end else if (!in_set || !key_level[KEY_INC] || state_change) begin
            hold_cnt  <= 8'd0;
            repeating <= 1'b0;
        end else if (sample_tick) begin
            if (hold_next == hold_target) begin
                hold_cnt  <= 8'd0;
                repeating <= 1'b1;
            end else begin
                hold_cnt  <= hold_next;
            end
        end
    end

    // INC forces digits visible, overriding a coincident blink toggle.
    always_comb begin
        phase_next = phase;
        if (state_change || inc_evt)
            phase_next = 1'b0;
        else if (blink_tick)
            phase_next = ~phase;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= SHOW_TIME;
            run_en       <= 1'b1;
            hour_load    <= 1'b0;
            minute_load  <= 1'b0;
            second_clear <= 1'b0;
            data_show    <= 12'd0;
            blank_mask   <= 2'b00;
            edit_hour    <= 5'd0;
            edit_min     <= 6'd0;
            phase        <= 1'b0;
        end else begin
            hour_load    <= 1'b0;
            minute_load  <= 1'b0;
            second_clear <= 1'b0;
            phase        <= phase_next;

            case (state)
                SHOW_SEC:         data_show <= {1'b1, 5'd0, second_in};
                SET_HOUR,
                SET_MIN:          data_show <= {1'b1, edit_hour, edit_min};
                SHOW_TIME,
                STOPPED:          data_show <= {1'b1, hour_in, minute_in};
                default:          data_show <= 12'd0;
            endcase

            if (state_change) begin
                // Phase is forced to 0 on any state change, so no blanking.
                blank_mask <= 2'b00;
                case (state)
                    SHOW_TIME: begin
                        state  <= SHOW_SEC;
                        run_en <= 1'b1;
                    end
                    SHOW_SEC: begin
                        state     <= SET_HOUR;
                        run_en    <= 1'b0;
                        edit_hour <= hour_in;
                        edit_min  <= minute_in;
                    end
                    SET_HOUR: begin
                        state  <= SET_MIN;
                        run_en <= 1'b0;
                    end
                    SET_MIN: begin
                        state        <= STOPPED;
                        run_en       <= 1'b0;
                        hour_load    <= 1'b1;
                        minute_load  <= 1'b1;
                        second_clear <= 1'b1;
                    end
                    default: begin
                        // STOPPED exit and recovery from unused codes.
                        state  <= SHOW_TIME;
                        run_en <= 1'b1;
                    end
                endcase
            end else begin
                if (inc_evt) begin
                    case (state)
                        SET_HOUR: edit_hour <= (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
                        SET_MIN:  edit_min  <= (edit_min  == 6'd59) ? 6'd0 : edit_min  + 6'd1;
                        STOPPED:  second_clear <= 1'b1;
                        default:  ;
                    endcase
                end
                case (state)
                    SET_HOUR: blank_mask <= {phase_next, 1'b0};
                    SET_MIN:  blank_mask <= {1'b0, phase_next};
                    default:  blank_mask <= 2'b00;
                endcase
            end
        end
    end

    assign mode         = state;
    assign hour_value   = edit_hour;
    assign minute_value = edit_min;
endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;
    localparam int DLY = 4;
    localparam int RT  = 2;

    logic        clock = 1'b0, reset = 1'b0;
    logic        sample_tick = 1'b0, blink_tick = 1'b0;
    logic        key_mode_raw = 1'b0, key_inc_raw = 1'b0;
    logic [4:0]  hour_in = 5'd0;
    logic [5:0]  minute_in = 6'd0, second_in = 6'd0;
    logic        run_en, hour_load, minute_load, second_clear;
    logic [4:0]  hour_value;
    logic [5:0]  minute_value;
    logic [2:0]  mode;
    logic [11:0] data_show;
    logic [1:0]  blank_mask;

    clock_set_controller #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RT)) dut (
        .clock(clock), .reset(reset), .sample_tick(sample_tick), .blink_tick(blink_tick),
        .key_mode_raw(key_mode_raw), .key_inc_raw(key_inc_raw),
        .hour_in(hour_in), .minute_in(minute_in), .second_in(second_in),
        .run_en(run_en), .hour_load(hour_load), .hour_value(hour_value),
        .minute_load(minute_load), .minute_value(minute_value),
        .second_clear(second_clear), .mode(mode), .data_show(data_show),
        .blank_mask(blank_mask)
    );

    always #5 clock = ~clock;

    int compared = 0, mismatched = 0;

    // Strobe monitor: counts strobe-high cycles and captures load values.
    int n_hl = 0, n_ml = 0, n_sc = 0, n_all = 0;
    logic [4:0] ld_h = 5'd0;
    logic [5:0] ld_m = 6'd0;
    logic [2:0] ld_mode = 3'd0;
    always @(negedge clock) begin
        if (hour_load) begin
            n_hl    <= n_hl + 1;
            ld_h    <= hour_value;
            ld_m    <= minute_value;
            ld_mode <= mode;
        end
        if (minute_load)  n_ml <= n_ml + 1;
        if (second_clear) n_sc <= n_sc + 1;
        if (hour_load && minute_load && second_clear) n_all <= n_all + 1;
    end

    // Reference model: state number as in the mode table, key sample history,
    // count of held ticks, blink phase and edit values.
    int       st;
    bit [3:0] ms, is_;
    int       k;
    bit       ph;
    int       eh, em;

    function automatic int ones(input bit [3:0] s);
        return int'(s[0]) + int'(s[1]) + int'(s[2]) + int'(s[3]);
    endfunction

    task automatic model_reset();
        st = 0; ms = 4'd0; is_ = 4'd0; k = 0; ph = 1'b0; eh = 0; em = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inc_action();
        if (st == 2) eh = (eh == 23) ? 0 : eh + 1;
        if (st == 3) em = (em == 59) ? 0 : em + 1;
        ph = 1'b0;
    endtask

    // One sample period: drive raw keys, let them pass the synchronizer,
    // fire sample_tick, optional blink (1: same cycle as tick, 2: later).
    task automatic step(input bit m, input bit i, input int bl, input bit rnd_live);
        bit lb_m, lb_i, rep, pm, pi;
        int e_hl, e_sc, e_all, h0, m0, s0, a0;
        logic [11:0] e_ds;
        logic [1:0]  e_bm;
        e_hl = 0; e_sc = 0; e_all = 0;
        h0 = n_hl; m0 = n_ml; s0 = n_sc; a0 = n_all;
        key_mode_raw = m; key_inc_raw = i;
        if (rnd_live && $urandom_range(2) == 0) begin
            hour_in   = 5'($urandom_range(23));
            minute_in = 6'($urandom_range(59));
            second_in = 6'($urandom_range(59));
        end
        @(negedge clock); @(negedge clock);
        sample_tick = 1'b1; blink_tick = (bl == 1);
        @(negedge clock);
        sample_tick = 1'b0; blink_tick = 1'b0;
        @(negedge clock);
        blink_tick = (bl == 2);
        @(negedge clock);
        blink_tick = 1'b0;
        @(negedge clock);

        lb_m = ones(ms) >= 3;
        lb_i = ones(is_) >= 3;
        rep = 1'b0;
        if ((st == 2 || st == 3) && lb_i) begin
            k++;
            rep = (k >= DLY) && ((k - DLY) % RT == 0);
        end else k = 0;
        if (rep) inc_action();
        else if (bl == 1) ph = ~ph;
        ms  = {ms[2:0], m};
        is_ = {is_[2:0], i};
        pm = (ones(ms) >= 3) && !lb_m;
        pi = (ones(is_) >= 3) && !lb_i;
        if (pm) begin
            ph = 1'b0; k = 0;
            case (st)
                0: st = 1;
                1: begin st = 2; eh = int'(hour_in); em = int'(minute_in); end
                2: st = 3;
                3: begin st = 4; e_hl = 1; e_sc = 1; e_all = 1; end
                default: st = 0;
            endcase
        end else if (pi) begin
            if (st == 2 || st == 3) inc_action();
            else if (st == 4) e_sc = 1;
        end
        if (bl == 2) ph = ~ph;

        e_ds = (st == 1) ? {1'b1, 5'd0, second_in} :
               (st == 2 || st == 3) ? {1'b1, 5'(eh), 6'(em)} : {1'b1, hour_in, minute_in};
        e_bm = (st == 2) ? {ph, 1'b0} : (st == 3) ? {1'b0, ph} : 2'b00;
        chk("mode", 32'(mode), 32'(st));
        chk("run_en", 32'(run_en), 32'(st < 2));
        chk("blank_mask", 32'(blank_mask), 32'(e_bm));
        chk("hour_value", 32'(hour_value), 32'(eh));
        chk("minute_value", 32'(minute_value), 32'(em));
        chk("data_show", 32'(data_show), 32'(e_ds));
        chk("hour_load_cycles", 32'(n_hl - h0), 32'(e_hl));
        chk("minute_load_cycles", 32'(n_ml - m0), 32'(e_hl));
        chk("second_clear_cycles", 32'(n_sc - s0), 32'(e_sc));
        chk("load_together", 32'(n_all - a0), 32'(e_all));
        if (e_all == 1) begin
            chk("load_hour_value", 32'(ld_h), 32'(eh));
            chk("load_minute_value", 32'(ld_m), 32'(em));
            chk("load_mode", 32'(ld_mode), 32'd4);
        end
    endtask

    task automatic press(input bit m, input bit i);
        for (int n = 0; n < 3; n++) step(m, i, 0, 1'b0);
        for (int n = 0; n < 2; n++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    int e0, h_before, loads_before;

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_run_en", 32'(run_en), 32'd1);
        chk("rst_data_show", 32'(data_show), 32'd0);
        chk("rst_blank", 32'(blank_mask), 32'd0);
        chk("rst_strobes", 32'({hour_load, minute_load, second_clear}), 32'd0);
        chk("rst_values", 32'({hour_value, minute_value}), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // MODE held for four ticks: SHOW_TIME -> SHOW_SEC.
        second_in = 6'd37;
        for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0); step(1'b0, 1'b0, 0, 1'b0);
        chk("plan_show_sec", 32'(data_show), 32'({1'b1, 5'd0, 6'd37}));

        // Edit with wrap on both fields, then commit.
        hour_in = 5'd23; minute_in = 6'd58;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("plan_hour_wrap", 32'(hour_value), 32'd0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("plan_min_wrap", 32'(minute_value), 32'd0);
        press(1'b1, 1'b0);
        chk("plan_load_h", 32'(ld_h), 32'd0);
        chk("plan_load_m", 32'(ld_m), 32'd0);
        chk("plan_stopped", 32'(mode), 32'd4);
        press(1'b0, 1'b1);           // STOPPED: INC clears seconds
        press(1'b1, 1'b0);           // back to SHOW_TIME
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);           // SET_HOUR

        // Bounce 1,0,1,1 -> one INC event.
        h_before = eh;
        step(1'b0, 1'b1, 0, 1'b0); step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0); step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0); step(1'b0, 1'b0, 0, 1'b0);
        chk("plan_bounce", 32'((int'(hour_value) + 24 - h_before) % 24), 32'd1);

        // MODE and INC together in SET_HOUR: MODE wins.
        h_before = eh;
        press(1'b1, 1'b1);
        chk("plan_same_mode", 32'(mode), 32'd3);
        chk("plan_same_hour", 32'(hour_value), 32'(h_before));

        // Hold INC in SET_MIN: press plus repeats, with blinks mixed in.
        e0 = em;
        for (int n = 0; n < 12; n++) step(1'b0, 1'b1, n % 3, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 0, 1'b0);
        chk("plan_hold_adv", 32'((int'(minute_value) + 60 - e0) % 60), 32'd5);

        // Randomised sequence with live counters changing underneath.
        for (int n = 0; n < 150; n++)
            step(1'($urandom_range(3) == 0), 1'($urandom_range(1)), int'($urandom_range(2)), 1'b1);
        step(1'b0, 1'b0, 0, 1'b0); step(1'b0, 1'b0, 0, 1'b0);

        // Reset in the middle of an edit discards it without loading.
        for (int n = 0; n < 8 && st != 3; n++) press(1'b1, 1'b0);
        chk("nav_set_min", 32'(mode), 32'd3);
        press(1'b0, 1'b1);
        loads_before = n_hl;
        reset = 1'b0;
        #1;
        chk("midrst_mode", 32'(mode), 32'd0);
        chk("midrst_run_en", 32'(run_en), 32'd1);
        chk("midrst_data_show", 32'(data_show), 32'd0);
        chk("midrst_values", 32'({hour_value, minute_value}), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 0, 1'b0);
        chk("midrst_no_load", 32'(n_hl), 32'(loads_before));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
